// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch clocked by mclk, counting clk_1hz rising edges,
// with start/pause/clear buttons and a multiplexed active-low 7-seg display.
module stopwatch_bcd #(
   parameter int SCAN_DIV = 1000,
   parameter int SCAN_W   = 10
) (
   input  logic       mclk,
   input  logic       rst,
   input  logic       clk_1hz,
   input  logic       btn_start,
   input  logic       btn_clear,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic       running,
   output logic       wrap,
   output logic [3:0] an,
   output logic [6:0] seg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic hz_q, start_q, clear_q;
   logic tick, start_e, clear_e;

   logic [3:0] so_q, so_d, mo_q, mo_d;
   logic [2:0] st_q, st_d, mt_q, mt_d;
   logic       wrap_q, wrap_d;

   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        an_q, an_d, dig;
   logic [6:0]        seg_q, seg_d;

   assign tick    = clk_1hz & ~hz_q;
   assign start_e = btn_start & ~start_q;
   assign clear_e = btn_clear & ~clear_q;

   always_comb begin
      state_d = state_q;
      if (clear_e) begin
         state_d = IDLE;
      end else if (start_e) begin
         unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Ripple carry through the BCD chain; wrap only on the full 59:59 rollover
   always_comb begin
      so_d   = so_q;
      st_d   = st_q;
      mo_d   = mo_q;
      mt_d   = mt_q;
      wrap_d = 1'b0;
      if (clear_e) begin
         so_d = '0;
         st_d = '0;
         mo_d = '0;
         mt_d = '0;
      end else if (tick && state_q == RUN) begin
         if (so_q == 4'd9) begin
            so_d = '0;
            if (st_q == 3'd5) begin
               st_d = '0;
               if (mo_q == 4'd9) begin
                  mo_d = '0;
                  if (mt_q == 3'd5) begin
                     mt_d   = '0;
                     wrap_d = 1'b1;
                  end else begin
                     mt_d = mt_q + 3'd1;
                  end
               end else begin
                  mo_d = mo_q + 4'd1;
               end
            end else begin
               st_d = st_q + 3'd1;
            end
         end else begin
            so_d = so_q + 4'd1;
         end
      end
   end

   always_comb begin
      scan_d = scan_q + SCAN_W'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_d = '0;
         idx_d  = idx_q + 2'd1;
      end
   end

   always_comb begin
      dig = 4'hF;
      unique case (idx_q)
         2'd0: dig = so_q;
         2'd1: dig = {1'b0, st_q};
         2'd2: dig = mo_q;
         2'd3: dig = {1'b0, mt_q};
      endcase
      an_d = ~(4'b0001 << idx_q);
      unique case (dig)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b1111111;
      endcase
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         hz_q    <= 1'b0;
         start_q <= 1'b0;
         clear_q <= 1'b0;
         so_q    <= '0;
         st_q    <= '0;
         mo_q    <= '0;
         mt_q    <= '0;
         wrap_q  <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         an_q    <= 4'b1110;
         seg_q   <= 7'b1000000;
      end else begin
         state_q <= state_d;
         hz_q    <= clk_1hz;
         start_q <= btn_start;
         clear_q <= btn_clear;
         so_q    <= so_d;
         st_q    <= st_d;
         mo_q    <= mo_d;
         mt_q    <= mt_d;
         wrap_q  <= wrap_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign sec_ones = so_q;
   assign sec_tens = st_q;
   assign min_ones = mo_q;
   assign min_tens = mt_q;
   assign running  = (state_q == RUN);
   assign wrap     = wrap_q;
   assign an       = an_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a seconds-based model queues the
// expected outputs per mclk edge; a monitor pops and compares after each edge.
module tb_stopwatch_bcd;

   logic       mclk = 1'b0;
   logic       rst = 1'b0;
   logic       clk_1hz = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic [3:0] sec_ones, min_ones, an;
   logic [2:0] sec_tens, min_tens;
   logic       running, wrap;
   logic [6:0] seg;

   stopwatch_bcd #(.SCAN_DIV(4), .SCAN_W(2)) dut (
      .mclk      (mclk),
      .rst       (rst),
      .clk_1hz   (clk_1hz),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .sec_ones  (sec_ones),
      .sec_tens  (sec_tens),
      .min_ones  (min_ones),
      .min_tens  (min_tens),
      .running   (running),
      .wrap      (wrap),
      .an        (an),
      .seg       (seg)
   );

   always #5 mclk = ~mclk;

   typedef struct packed {
      logic [13:0] t;
      logic [1:0]  c;
      logic [10:0] d;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Model state: time held as plain seconds 0..3599
   int   m_sec, m_state, m_sc, m_idx;
   logic m_h, m_s, m_c;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] segtab(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [13:0] tpack(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int digit(input int s, input int i);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      case (i)
         0: return ss % 10;
         1: return ss / 10;
         2: return mm % 10;
         default: return mm / 10;
      endcase
   endfunction

   task automatic model_reset();
      m_sec = 0; m_state = 0; m_sc = 0; m_idx = 0;
      m_h = 0; m_s = 0; m_c = 0;
   endtask

   // Called at a negedge: apply inputs, queue expectation, advance one cycle
   task automatic drive(input logic hz, input logic st, input logic cl);
      exp_t e;
      logic tk, se, ce, wr;
      clk_1hz = hz; btn_start = st; btn_clear = cl;
      tk = hz & ~m_h; se = st & ~m_s; ce = cl & ~m_c;
      m_h = hz; m_s = st; m_c = cl;
      e.d = {~(4'b0001 << m_idx), segtab(digit(m_sec, m_idx))};
      if (m_sc == 3) begin
         m_sc = 0;
         m_idx = (m_idx + 1) % 4;
      end else begin
         m_sc++;
      end
      wr = 1'b0;
      if (ce) begin
         m_sec = 0;
         m_state = 0;
      end else begin
         if (tk && m_state == 1) begin
            if (m_sec == 3599) begin
               m_sec = 0;
               wr = 1'b1;
            end else begin
               m_sec++;
            end
         end
         if (se) m_state = (m_state == 1) ? 2 : 1;
      end
      e.t = tpack(m_sec);
      e.c = {logic'(m_state == 1), wr};
      q.push_back(e);
      @(negedge mclk);
   endtask

   task automatic ticks(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         repeat (half) drive(1'b1, 1'b0, 1'b0);
         repeat (half) drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic press_start();
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_clear();
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   always @(posedge mclk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(e.t));
         check("ctl", 32'({running, wrap}), 32'(e.c));
         check("disp", 32'({an, seg}), 32'(e.d));
      end
   end

   logic [13:0] now;
   assign now = {min_tens, min_ones, sec_tens, sec_ones};

   initial begin
      model_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge mclk);
         clk_1hz = logic'(i[0]); btn_start = ~logic'(i[0]); btn_clear = logic'(i[1]);
      end
      check("rst_time", 32'(now), 32'(0));
      check("rst_run", 32'({running, wrap}), 32'(0));
      check("rst_an", 32'(an), 32'(4'b1110));
      check("rst_seg", 32'(seg), 32'(7'b1000000));
      @(negedge mclk);
      clk_1hz = 0; btn_start = 0; btn_clear = 0;
      rst = 1'b1;

      press_start();
      ticks(12, 5);
      check("count12", 32'(now), 32'(tpack(12)));

      press_clear();
      press_start();
      ticks(5, 5);
      press_start();
      ticks(3, 5);
      check("pause_time", 32'(now), 32'(tpack(5)));
      check("pause_run", 32'(running), 32'(0));
      press_start();
      ticks(1, 5);
      check("resume", 32'(now), 32'(tpack(6)));

      press_clear();
      press_start();
      ticks(3598, 1);
      check("preload", 32'(now), 32'(tpack(3598)));
      ticks(2, 5);
      check("rollover", 32'(now), 32'(0));
      check("roll_run", 32'(running), 32'(1));

      press_clear();
      press_start();
      ticks(9, 2);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("clr_tick", 32'({now, running, wrap}), 32'(0));
      press_start();
      ticks(3, 2);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check("st_tick", 32'({now, running}), 32'({tpack(4), 1'b0}));

      press_clear();
      press_start();
      ticks(754, 1);
      press_start();
      repeat (20) drive(1'b0, 1'b0, 1'b0);
      check("scan_time", 32'(now), 32'(tpack(754)));

      press_start();
      ticks(2, 2);
      rst = 1'b0;
      #1;
      check("arst_time", 32'({now, running, wrap}), 32'(0));
      check("arst_disp", 32'({an, seg}), 32'({4'b1110, 7'b1000000}));
      @(negedge mclk);
      @(negedge mclk);
      model_reset();
      btn_start = 1'b1;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      ticks(2, 2);
      check("hot_release", 32'({now, running}), 32'({tpack(0), 1'b0}));
      press_start();
      ticks(2, 2);
      check("after_hot", 32'({now, running}), 32'({tpack(2), 1'b1}));

      @(negedge mclk);
      check("queue_empty", 32'(q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
